// File: rtl/amp_menu_if.sv
// Event, LCD-handshake and parameter-output bundle between the rotary front-end,
// amp_menu_ctrl, lcd_driver and the audio datapath.
interface amp_menu_if #(
  parameter int unsigned VOL_W  = 6,
  parameter int unsigned TONE_W = 4
);
  logic [1:0]        action;
  logic              start;
  logic              lcd_ack;
  logic              lcd_req;
  logic [1:0]        lcd_item;
  logic              lcd_edit;
  logic [VOL_W-1:0]  lcd_value;
  logic [VOL_W-1:0]  volume;
  logic [TONE_W-1:0] bass;
  logic [TONE_W-1:0] treble;
  logic              mute;
  logic              overflow;

  modport master (
    input  action, start, lcd_ack,
    output lcd_req, lcd_item, lcd_edit, lcd_value,
           volume, bass, treble, mute, overflow
  );

  modport slave (
    output action, start, lcd_ack,
    input  lcd_req, lcd_item, lcd_edit, lcd_value,
           volume, bass, treble, mute, overflow
  );
endinterface

// File: rtl/amp_menu_ctrl.sv
// Amplifier user menu: browse/edit FSM, parameter registers and LCD refresh handshake.
// Optional macro AUTO_EXIT_EN: edit mode returns to browse after TIMEOUT_CYCLES idle cycles.
module amp_menu_ctrl #(
  parameter int unsigned VOL_W          = 6,
  parameter int unsigned VOL_MAX        = 63,
  parameter int unsigned VOL_DEFAULT    = 32,
  parameter int unsigned TONE_W         = 4,
  parameter int unsigned TONE_MAX       = 15,
  parameter int unsigned TONE_DEFAULT   = 8,
  parameter int unsigned STEP           = 1,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  amp_menu_if.master bus
);
  typedef enum logic [1:0] {ST_BROWSE, ST_EDIT, ST_LCD_WAIT} state_t;

  localparam logic [1:0] ACT_LEFT    = 2'd1;
  localparam logic [1:0] ACT_RIGHT   = 2'd2;
  localparam logic [1:0] ACT_PRESS   = 2'd3;
  localparam logic [1:0] ITEM_VOL    = 2'd0;
  localparam logic [1:0] ITEM_BASS   = 2'd1;
  localparam logic [1:0] ITEM_TREBLE = 2'd2;
  localparam logic [1:0] ITEM_MUTE   = 2'd3;

  // Reject parameter sets whose limits or defaults do not fit their registers.
  if (VOL_MAX >= (2 ** VOL_W) || TONE_MAX >= (2 ** TONE_W) || VOL_DEFAULT > VOL_MAX ||
      TONE_DEFAULT > TONE_MAX || TONE_W > VOL_W || STEP == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("amp_menu_ctrl: inconsistent parameters");
  end

  state_t              state_q, state_d;
  logic                edit_q, edit_d;
  logic [1:0]          item_q, item_d;
  logic [VOL_W-1:0]    vol_q, vol_d;
  logic [TONE_W-1:0]   bass_q, bass_d;
  logic [TONE_W-1:0]   treble_q, treble_d;
  logic                mute_q, mute_d;
  logic [VOL_W-1:0]    lcd_value_q, lcd_value_d;
  logic                req_q, req_d;
  logic                pend_v_q, pend_v_d;
  logic [1:0]          pend_act_q, pend_act_d;
  logic                ovf_q, ovf_d;
  logic                consume;
  logic                changed;
  logic                up;

  // Saturating step toward max_v (up) or toward zero (down).
  function automatic int unsigned step_val(input int unsigned cur, input logic dir_up,
                                           input int unsigned max_v);
    int unsigned res;
    if (dir_up) res = (cur + STEP > max_v) ? max_v : cur + STEP;
    else        res = (cur < STEP) ? 0 : cur - STEP;
    return res;
  endfunction

  assign consume = pend_v_q && (state_q != ST_LCD_WAIT);
  assign up      = (pend_act_q == ACT_RIGHT);

`ifdef AUTO_EXIT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             timeout;

  assign timeout = (state_q == ST_EDIT) && !consume && (idle_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: cleared by any consumed event, frozen outside EDIT.
  always_comb begin
    idle_d = idle_q;
    if (consume || timeout)     idle_d = '0;
    else if (state_q == ST_EDIT) idle_d = idle_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`endif

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    item_d     = item_q;
    vol_d      = vol_q;
    bass_d     = bass_q;
    treble_d   = treble_q;
    mute_d     = mute_q;
    req_d      = req_q;
    ovf_d      = ovf_q;
    pend_v_d   = pend_v_q && !consume;
    pend_act_d = pend_act_q;
    changed    = 1'b0;

    if (consume) begin
      if (!edit_q) begin
        unique case (pend_act_q)
          ACT_LEFT:  item_d = item_q - 2'd1;
          ACT_RIGHT: item_d = item_q + 2'd1;
          default:   edit_d = 1'b1;
        endcase
        changed = 1'b1;
      end else if (pend_act_q == ACT_PRESS) begin
        edit_d  = 1'b0;
        changed = 1'b1;
      end else begin
        unique case (item_q)
          ITEM_VOL:    vol_d    = VOL_W'(step_val(32'(vol_q), up, VOL_MAX));
          ITEM_BASS:   bass_d   = TONE_W'(step_val(32'(bass_q), up, TONE_MAX));
          ITEM_TREBLE: treble_d = TONE_W'(step_val(32'(treble_q), up, TONE_MAX));
          default:     mute_d   = ~mute_q;
        endcase
        changed = (vol_d != vol_q) || (bass_d != bass_q) ||
                  (treble_d != treble_q) || (mute_d != mute_q);
      end
    end
`ifdef AUTO_EXIT_EN
    if (timeout) begin
      edit_d  = 1'b0;
      changed = 1'b1;
    end
`endif

    if (changed) begin
      req_d   = 1'b1;
      state_d = ST_LCD_WAIT;
    end else if (state_q == ST_LCD_WAIT && bus.lcd_ack) begin
      req_d   = 1'b0;
      state_d = edit_q ? ST_EDIT : ST_BROWSE;
    end

    // New event: loads if the slot is free or being consumed now, otherwise dropped.
    if (bus.start && bus.action != 2'd0) begin
      if (pend_v_d) begin
        ovf_d = 1'b1;
      end else begin
        pend_v_d   = 1'b1;
        pend_act_d = bus.action;
      end
    end

    unique case (item_d)
      ITEM_VOL:    lcd_value_d = vol_d;
      ITEM_BASS:   lcd_value_d = VOL_W'(bass_d);
      ITEM_TREBLE: lcd_value_d = VOL_W'(treble_d);
      default:     lcd_value_d = VOL_W'(mute_d);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BROWSE;
      edit_q      <= 1'b0;
      item_q      <= ITEM_VOL;
      vol_q       <= VOL_W'(VOL_DEFAULT);
      bass_q      <= TONE_W'(TONE_DEFAULT);
      treble_q    <= TONE_W'(TONE_DEFAULT);
      mute_q      <= 1'b0;
      lcd_value_q <= VOL_W'(VOL_DEFAULT);
      req_q       <= 1'b0;
      pend_v_q    <= 1'b0;
      pend_act_q  <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      edit_q      <= edit_d;
      item_q      <= item_d;
      vol_q       <= vol_d;
      bass_q      <= bass_d;
      treble_q    <= treble_d;
      mute_q      <= mute_d;
      lcd_value_q <= lcd_value_d;
      req_q       <= req_d;
      pend_v_q    <= pend_v_d;
      pend_act_q  <= pend_act_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.lcd_req   = req_q;
  assign bus.lcd_item  = item_q;
  assign bus.lcd_edit  = edit_q;
  assign bus.lcd_value = lcd_value_q;
  assign bus.volume    = vol_q;
  assign bus.bass      = bass_q;
  assign bus.treble    = treble_q;
  assign bus.mute      = mute_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_amp_menu_ctrl.sv
// Directed bench for amp_menu_ctrl: vector table for menu navigation/editing plus
// hand sequences for saturation, overflow, reset mid-handshake and auto-exit.
module tb_amp_menu_ctrl;
  localparam logic [1:0] A_NONE  = 2'd0;
  localparam logic [1:0] A_LEFT  = 2'd1;
  localparam logic [1:0] A_RIGHT = 2'd2;
  localparam logic [1:0] A_PRESS = 2'd3;
  localparam int NVEC = 21;

  typedef struct {
    logic [1:0] act;
    logic [1:0] item;
    logic       edit;
    logic [5:0] value;
    logic [5:0] vol;
    logic [3:0] bass;
    logic [3:0] treble;
    logic       mute;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[NVEC];

  amp_menu_if #(.VOL_W(6), .TONE_W(4)) bus ();

  amp_menu_ctrl #(
    .VOL_W(6), .VOL_MAX(63), .VOL_DEFAULT(32), .TONE_W(4), .TONE_MAX(15),
    .TONE_DEFAULT(8), .STEP(1), .TIMEOUT_CYCLES(100)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; start is high for exactly one posedge.
  task automatic send(input logic [1:0] a);
    bus.start  = 1'b1;
    bus.action = a;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.action = A_NONE;
  endtask

  task automatic ack();
    bus.lcd_ack = 1'b1;
    @(negedge clk);
    bus.lcd_ack = 1'b0;
    chk("ack_drops_req", 32'(bus.lcd_req), 32'd0);
  endtask

  task automatic ack_if_req();
    for (int i = 0; i < 5 && !bus.lcd_req; i++) @(negedge clk);
    if (bus.lcd_req) ack();
  endtask

  // Request must appear exactly two edges after start is sampled.
  task automatic do_evt(input logic [1:0] a, input logic exp_req, input string name);
    send(a);
    @(negedge clk);
    chk({name, "_req"}, 32'(bus.lcd_req), 32'(exp_req));
  endtask

  function automatic logic [31:0] lcd_word();
    return 32'({bus.lcd_item, bus.lcd_edit, bus.lcd_value});
  endfunction

  function automatic logic [31:0] par_word();
    return 32'({bus.volume, bus.bass, bus.treble, bus.mute});
  endfunction

  function automatic logic [31:0] par_exp(input logic [5:0] v, input logic [3:0] b,
                                          input logic [3:0] t, input logic m);
    return 32'({v, b, t, m});
  endfunction

  initial begin
    int n;
    vecs[0]  = '{A_RIGHT, 2'd1, 1'b0, 6'd8,  6'd32, 4'd8, 4'd8, 1'b0};
    vecs[1]  = '{A_LEFT,  2'd0, 1'b0, 6'd32, 6'd32, 4'd8, 4'd8, 1'b0};
    vecs[2]  = '{A_LEFT,  2'd3, 1'b0, 6'd0,  6'd32, 4'd8, 4'd8, 1'b0};
    vecs[3]  = '{A_RIGHT, 2'd0, 1'b0, 6'd32, 6'd32, 4'd8, 4'd8, 1'b0};
    vecs[4]  = '{A_PRESS, 2'd0, 1'b1, 6'd32, 6'd32, 4'd8, 4'd8, 1'b0};
    vecs[5]  = '{A_RIGHT, 2'd0, 1'b1, 6'd33, 6'd33, 4'd8, 4'd8, 1'b0};
    vecs[6]  = '{A_LEFT,  2'd0, 1'b1, 6'd32, 6'd32, 4'd8, 4'd8, 1'b0};
    vecs[7]  = '{A_PRESS, 2'd0, 1'b0, 6'd32, 6'd32, 4'd8, 4'd8, 1'b0};
    vecs[8]  = '{A_RIGHT, 2'd1, 1'b0, 6'd8,  6'd32, 4'd8, 4'd8, 1'b0};
    vecs[9]  = '{A_PRESS, 2'd1, 1'b1, 6'd8,  6'd32, 4'd8, 4'd8, 1'b0};
    vecs[10] = '{A_LEFT,  2'd1, 1'b1, 6'd7,  6'd32, 4'd7, 4'd8, 1'b0};
    vecs[11] = '{A_PRESS, 2'd1, 1'b0, 6'd7,  6'd32, 4'd7, 4'd8, 1'b0};
    vecs[12] = '{A_RIGHT, 2'd2, 1'b0, 6'd8,  6'd32, 4'd7, 4'd8, 1'b0};
    vecs[13] = '{A_PRESS, 2'd2, 1'b1, 6'd8,  6'd32, 4'd7, 4'd8, 1'b0};
    vecs[14] = '{A_RIGHT, 2'd2, 1'b1, 6'd9,  6'd32, 4'd7, 4'd9, 1'b0};
    vecs[15] = '{A_PRESS, 2'd2, 1'b0, 6'd9,  6'd32, 4'd7, 4'd9, 1'b0};
    vecs[16] = '{A_RIGHT, 2'd3, 1'b0, 6'd0,  6'd32, 4'd7, 4'd9, 1'b0};
    vecs[17] = '{A_PRESS, 2'd3, 1'b1, 6'd0,  6'd32, 4'd7, 4'd9, 1'b0};
    vecs[18] = '{A_RIGHT, 2'd3, 1'b1, 6'd1,  6'd32, 4'd7, 4'd9, 1'b1};
    vecs[19] = '{A_LEFT,  2'd3, 1'b1, 6'd0,  6'd32, 4'd7, 4'd9, 1'b0};
    vecs[20] = '{A_PRESS, 2'd3, 1'b0, 6'd0,  6'd32, 4'd7, 4'd9, 1'b0};

    rst_n       = 1'b0;
    bus.start   = 1'b0;
    bus.action  = A_NONE;
    bus.lcd_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req", 32'(bus.lcd_req), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_par", par_word(), par_exp(6'd32, 4'd8, 4'd8, 1'b0));
    chk("rst_lcd", lcd_word(), 32'({2'd0, 1'b0, 6'd32}));

    // Navigation and editing vectors, each acknowledged before the next.
    for (int i = 0; i < NVEC; i++) begin
      do_evt(vecs[i].act, 1'b1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_lcd", i), lcd_word(), 32'({vecs[i].item, vecs[i].edit, vecs[i].value}));
      ack_if_req();
      chk($sformatf("vec%0d_par", i), par_word(),
          par_exp(vecs[i].vol, vecs[i].bass, vecs[i].treble, vecs[i].mute));
    end

    // Volume saturation at 63: further rights are consumed silently.
    do_evt(A_RIGHT, 1'b1, "sat_item0"); ack_if_req();
    do_evt(A_PRESS, 1'b1, "sat_edit");  ack_if_req();
    for (int i = 0; i < 30; i++) begin
      do_evt(A_RIGHT, 1'b1, "vol_up"); ack_if_req();
    end
    chk("vol_62", 32'(bus.volume), 32'd62);
    do_evt(A_RIGHT, 1'b1, "vol_63"); ack_if_req();
    chk("vol_63", 32'(bus.volume), 32'd63);
    do_evt(A_RIGHT, 1'b0, "vol_sat1"); ack_if_req();
    do_evt(A_RIGHT, 1'b0, "vol_sat2"); ack_if_req();
    chk("vol_sat_val", 32'(bus.volume), 32'd63);
    chk("vol_sat_lcd", lcd_word(), 32'({2'd0, 1'b1, 6'd63}));

    // Bass floor at 0.
    do_evt(A_PRESS, 1'b1, "b_exit");  ack_if_req();
    do_evt(A_RIGHT, 1'b1, "b_item");  ack_if_req();
    do_evt(A_PRESS, 1'b1, "b_edit");  ack_if_req();
    for (int i = 0; i < 6; i++) begin
      do_evt(A_LEFT, 1'b1, "bass_dn"); ack_if_req();
    end
    chk("bass_1", 32'(bus.bass), 32'd1);
    do_evt(A_LEFT, 1'b1, "bass_0"); ack_if_req();
    do_evt(A_LEFT, 1'b0, "bass_sat"); ack_if_req();
    chk("bass_sat_val", 32'(bus.bass), 32'd0);
    do_evt(A_PRESS, 1'b1, "b_done"); ack_if_req();

    // Overflow: A consumed, B loaded on the consume edge, C dropped.
    chk("ovf_before", 32'(bus.overflow), 32'd0);
    send(A_RIGHT);
    send(A_LEFT);
    send(A_PRESS);
    chk("ovf_set", 32'(bus.overflow), 32'd1);
    chk("ovf_req", 32'(bus.lcd_req), 32'd1);
    chk("ovf_frozen", lcd_word(), 32'({2'd2, 1'b0, 6'd9}));
    repeat (3) @(negedge clk);
    chk("ovf_held", lcd_word(), 32'({2'd2, 1'b0, 6'd9}));
    ack();
    @(negedge clk);
    chk("ovf_b_req", 32'(bus.lcd_req), 32'd1);
    chk("ovf_b_lcd", lcd_word(), 32'({2'd1, 1'b0, 6'd0}));
    ack();
    repeat (5) @(negedge clk);
    chk("ovf_c_never", 32'({bus.lcd_req, bus.lcd_edit, bus.lcd_item}), 32'({1'b0, 1'b0, 2'd1}));

    // Reset in the middle of a handshake with an event pending.
    send(A_RIGHT);
    send(A_LEFT);
    chk("mid_req", 32'(bus.lcd_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(bus.lcd_req), 32'd0);
    chk("mid_rst_ovf", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_no_req", 32'(bus.lcd_req), 32'd0);
    chk("mid_lcd", lcd_word(), 32'({2'd0, 1'b0, 6'd32}));

    // start with action none, and ack outside LCD_WAIT, are both ignored.
    send(A_NONE);
    repeat (3) @(negedge clk);
    chk("none_ignored", 32'({bus.lcd_req, bus.overflow}), 32'd0);
    bus.lcd_ack = 1'b1;
    @(negedge clk);
    bus.lcd_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_ack", 32'({bus.lcd_req, bus.lcd_item, bus.lcd_edit}), 32'd0);
    do_evt(A_RIGHT, 1'b1, "post_ack"); ack_if_req();
    chk("post_ack_item", 32'(bus.lcd_item), 32'd1);
    do_evt(A_LEFT, 1'b1, "back0"); ack_if_req();

`ifdef AUTO_EXIT_EN
    do_evt(A_PRESS, 1'b1, "ae_edit"); ack_if_req();
    n = 0;
    while (!bus.lcd_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ae_cycles", 32'(n), 32'd100);
    chk("ae_edit_off", 32'(bus.lcd_edit), 32'd0);
    ack_if_req();
    do_evt(A_PRESS, 1'b1, "ae_edit2"); ack_if_req();
    repeat (90) @(negedge clk);
    do_evt(A_LEFT, 1'b1, "ae_restart"); ack_if_req();
    n = 0;
    while (!bus.lcd_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("ae_cycles2", 32'(n), 32'd100);
    chk("ae_vol", 32'({bus.volume, bus.lcd_edit}), 32'({6'd31, 1'b0}));
    ack_if_req();
`else
    n = 0;
    do_evt(A_PRESS, 1'b1, "stay_edit"); ack_if_req();
    repeat (150) @(negedge clk);
    chk("edit_persists", 32'({bus.lcd_req, bus.lcd_edit}), 32'({1'b0, 1'b1}));
    chk("idle_len", 32'(n), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
